ram_arbiter: RTL and testbench

- Multicore RAM arbiter and sequencer.
- Sits between the per-CPU I-caches/D-caches and the single shared RAM port.
- Registers one grant at a time and holds it until the RAM reports ACCESS.
- Round-robin across CPUs; within a CPU, data beats instruction. Replaces the fixed-priority single-core path.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/rr_picker.sv | 25 ++
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types: word and RAM handshake encodings plus the arbiter's own
// state and source enums.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        SRC_D = 1'b0,
        SRC_I = 1'b1
    } arb_src_t;

    localparam int TCNT_W = 8;

endpackage

// File: rtl/rr_picker.sv
// Rotating priority encoder: returns the first requester at or after rr_ptr,
// wrapping modulo CPUS.
module rr_picker #(
    parameter int CPUS = 2,
    parameter int CIDW = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic [CPUS-1:0] any,
    input  logic [CIDW-1:0] rr_ptr,
    output logic            valid,
    output logic [CIDW-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Scan farthest offset first so the one nearest rr_ptr overwrites last.
        for (int k = CPUS - 1; k >= 0; k--) begin
            if (any[(int'(rr_ptr) + k) % CPUS]) begin
                valid = 1'b1;
                idx   = CIDW'((int'(rr_ptr) + k) % CPUS);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Multicore RAM arbiter: round-robin across CPUs, data before instruction within
// a CPU, one grant held until ACCESS. Optional forced release with ARB_TIMEOUT_EN.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 255,
    parameter int CIDW    = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  word_t [CPUS-1:0]     iaddr,
    input  word_t [CPUS-1:0]     daddr,
    input  word_t [CPUS-1:0]     dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output word_t [CPUS-1:0]     iload,
    output word_t [CPUS-1:0]     dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    input  word_t                ramload,
    input  ramstate_t            ramstate,
    output logic [CIDW-1:0]      gnt_cpu,
    output logic                 busy,
    output logic                 timeout
);

    logic [CPUS-1:0] d_req, i_req, any;
    logic            pick_vld;
    logic [CIDW-1:0] pick_idx;

    arb_state_t      state_q, state_d;
    arb_src_t        gnt_src_q, gnt_src_d;
    logic [CIDW-1:0] gnt_cpu_q, gnt_cpu_d;
    logic [CIDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CIDW-1:0] rr_next;
    logic            gnt_live;

    assign d_req = dREN | dWEN;
    assign i_req = iREN;
    assign any   = d_req | i_req;

    rr_picker #(.CPUS(CPUS), .CIDW(CIDW)) u_pick (
        .any    (any),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_vld),
        .idx    (pick_idx)
    );

    assign rr_next  = (gnt_cpu_q == CIDW'(CPUS - 1)) ? '0 : gnt_cpu_q + 1'b1;
    assign gnt_live = (gnt_src_q == SRC_D) ? d_req[gnt_cpu_q] : i_req[gnt_cpu_q];

    // Load buses are broadcast; only the CPU whose wait drops consumes them.
    assign iload   = {CPUS{ramload}};
    assign dload   = {CPUS{ramload}};
    assign gnt_cpu = gnt_cpu_q;
    assign busy    = (state_q == ARB_BUSY);

`ifdef ARB_TIMEOUT_EN
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              timeout_q, timeout_d;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_cpu_d = gnt_cpu_q;
        gnt_src_d = gnt_src_q;
        rr_ptr_d  = rr_ptr_q;
        iwait     = '1;
        dwait     = '1;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
`ifdef ARB_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d   = ARB_BUSY;
                    gnt_cpu_d = pick_idx;
                    gnt_src_d = d_req[pick_idx] ? SRC_D : SRC_I;
`ifdef ARB_TIMEOUT_EN
                    tcnt_d    = '0;
`endif
                end
            end
            ARB_BUSY: begin
                if (gnt_src_q == SRC_D) begin
                    ramWEN   = dWEN[gnt_cpu_q];
                    ramREN   = dREN[gnt_cpu_q] & ~dWEN[gnt_cpu_q];
                    ramaddr  = daddr[gnt_cpu_q];
                    ramstore = dstore[gnt_cpu_q];
                end else begin
                    ramREN   = 1'b1;
                    ramaddr  = iaddr[gnt_cpu_q];
                end
                // A withdrawn request drops the grant silently and keeps rr_ptr.
                if (!gnt_live) begin
                    state_d = ARB_IDLE;
                end else if (ramstate == ACCESS) begin
                    if (gnt_src_q == SRC_D) dwait[gnt_cpu_q] = 1'b0;
                    else                    iwait[gnt_cpu_q] = 1'b0;
                    state_d  = ARB_IDLE;
                    rr_ptr_d = rr_next;
                end
`ifdef ARB_TIMEOUT_EN
                else if ({1'b0, tcnt_q} + 9'd1 == 9'(TIMEOUT)) begin
                    state_d   = ARB_IDLE;
                    timeout_d = 1'b1;
                    rr_ptr_d  = rr_next;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ARB_IDLE;
            gnt_cpu_q <= '0;
            gnt_src_q <= SRC_D;
            rr_ptr_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_cpu_q <= gnt_cpu_d;
            gnt_src_q <= gnt_src_d;
            rr_ptr_q  <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (CPUS=2, TIMEOUT=4); covers ARB_TIMEOUT_EN
// when that macro is defined, otherwise checks the grant is held.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    logic            CLK, RST;
    logic [1:0]      iREN, dREN, dWEN, iwait, dwait;
    word_t [1:0]     iaddr, daddr, dstore, iload, dload;
    logic            ramREN, ramWEN, busy, timeout;
    word_t           ramaddr, ramstore, ramload;
    ramstate_t       ramstate;
    logic [0:0]      gnt_cpu;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.CPUS(2), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
        .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .gnt_cpu(gnt_cpu), .busy(busy), .timeout(timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        RST = 1'b1;
        #1;
        checks++;
        if ({busy, timeout, ramREN, ramWEN, iwait, dwait, gnt_cpu} !== 9'b0000_1111_0 ||
            ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got ctl=%b addr=%h store=%h want ctl=000011110 addr=0 store=0",
                     {busy, timeout, ramREN, ramWEN, iwait, dwait, gnt_cpu}, ramaddr, ramstore);
        end
        @(negedge CLK);
        RST = 1'b0; dREN = 2'b01; daddr[0] = 32'h80; ramstate = BUSY;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_latency busy=%b want 0", busy); end
        @(negedge CLK); #1;
        checks++;
        if ({busy, ramREN, ramaddr} !== {2'b11, 32'h80}) begin
            errors++; $display("FAIL reset_pre_busy busy=%b ren=%b addr=%h want 1 1 80", busy, ramREN, ramaddr);
        end
        #1 RST = 1'b1;
        #1;
        checks++;
        if ({busy, ramREN, iwait, dwait} !== 6'b00_1111 || ramaddr !== 32'h0) begin
            errors++; $display("FAIL reset_mid_busy got %b addr=%h want 001111 addr=0", {busy, ramREN, iwait, dwait}, ramaddr);
        end
        dREN = 2'b00; ramstate = FREE;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_single_fetch();
        @(negedge CLK);
        iREN = 2'b01; iaddr[0] = 32'h0000_0040;
        #1;
        checks++;
        if ({busy, ramREN, iwait} !== 4'b0011) begin
            errors++; $display("FAIL fetch_idle got %b want 0011", {busy, ramREN, iwait});
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            ramstate = (c == 3) ? ACCESS : BUSY;
            ramload  = 32'h2401_0005;
            #1;
            checks++;
            if ({busy, ramREN, ramWEN, gnt_cpu} !== 4'b1100 || ramaddr !== 32'h40 ||
                iwait !== ((c == 3) ? 2'b10 : 2'b11) || dwait !== 2'b11) begin
                errors++;
                $display("FAIL fetch_busy_c%0d ctl=%b addr=%h iwait=%b dwait=%b want 1100 40 %b 11",
                         c, {busy, ramREN, ramWEN, gnt_cpu}, ramaddr, iwait, dwait, (c == 3) ? 2'b10 : 2'b11);
            end
        end
        checks++;
        if (iload[0] !== 32'h2401_0005) begin errors++; $display("FAIL fetch_iload got %h want 24010005", iload[0]); end
        @(negedge CLK);
        iREN = 2'b00; ramstate = FREE;
        #1;
        checks++;
        if ({busy, iwait} !== 3'b011) begin errors++; $display("FAIL fetch_one_cycle got %b want 011", {busy, iwait}); end
    endtask

    task automatic test_priority();
        @(negedge CLK);
        dWEN = 2'b01; dREN = 2'b01; iREN = 2'b01;
        daddr[0] = 32'h100; dstore[0] = 32'hDEAD_BEEF; iaddr[0] = 32'h44;
        @(negedge CLK);
        ramstate = ACCESS; ramload = 32'h1111_2222;
        #1;
        checks++;
        if ({busy, ramWEN, ramREN, gnt_cpu, iwait, dwait} !== 8'b1100_11_10 ||
            ramaddr !== 32'h100 || ramstore !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL prio_data ctl=%b addr=%h store=%h want 11001110 100 deadbeef",
                     {busy, ramWEN, ramREN, gnt_cpu, iwait, dwait}, ramaddr, ramstore);
        end
        @(negedge CLK);
        dWEN = 2'b00; dREN = 2'b00; ramstate = FREE;
        #1;
        checks++;
        if ({busy, dwait} !== 3'b011) begin errors++; $display("FAIL prio_gap got %b want 011", {busy, dwait}); end
        @(negedge CLK);
        ramstate = ACCESS; ramload = 32'h3333_4444;
        #1;
        checks++;
        if ({busy, ramWEN, ramREN, gnt_cpu, iwait, dwait} !== 8'b1010_10_11 ||
            ramaddr !== 32'h44 || ramstore !== 32'h0 || iload[0] !== 32'h3333_4444) begin
            errors++;
            $display("FAIL prio_instr ctl=%b addr=%h store=%h iload=%h want 10101011 44 0 33334444",
                     {busy, ramWEN, ramREN, gnt_cpu, iwait, dwait}, ramaddr, ramstore, iload[0]);
        end
        @(negedge CLK);
        iREN = 2'b00; ramstate = FREE;
    endtask

    task automatic test_round_robin();
        logic exp;
        exp = 1'b1;  // CPU0 completed last, so the pointer sits on CPU1
        dREN = 2'b11; daddr[0] = 32'h200; daddr[1] = 32'h300;
        for (int g = 0; g < 4; g++) begin
            @(negedge CLK);
            ramstate = BUSY;
            #1;
            checks++;
            if (busy !== 1'b1 || gnt_cpu !== exp || ramaddr !== (exp ? 32'h300 : 32'h200) || dwait !== 2'b11) begin
                errors++;
                $display("FAIL rr_grant%0d busy=%b gnt=%0d addr=%h dwait=%b want gnt=%0d", g, busy, gnt_cpu, ramaddr, dwait, exp);
            end
            @(negedge CLK);
            ramstate = ACCESS; ramload = 32'(g);
            #1;
            checks++;
            if (dwait !== (exp ? 2'b01 : 2'b10) || dload[exp] !== 32'(g)) begin
                errors++;
                $display("FAIL rr_done%0d dwait=%b dload=%h want %b %h", g, dwait, dload[exp], exp ? 2'b01 : 2'b10, g);
            end
            @(negedge CLK);
            ramstate = FREE;
            #1;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL rr_spacing%0d busy=%b want 0", g, busy); end
            exp = ~exp;
        end
        dREN = 2'b00;
    endtask

    task automatic test_withdrawal();
        @(negedge CLK);
        dREN = 2'b10; daddr[1] = 32'h500; ramstate = BUSY;
        @(negedge CLK); #1;
        checks++;
        if ({busy, gnt_cpu} !== 2'b11) begin errors++; $display("FAIL wd_grant got %b want 11", {busy, gnt_cpu}); end
        @(negedge CLK);
        dREN = 2'b00;
        #1;
        checks++;
        if ({busy, ramREN, dwait} !== 4'b1011) begin errors++; $display("FAIL wd_drop got %b want 1011", {busy, ramREN, dwait}); end
        @(negedge CLK);
        dREN = 2'b11;
        #1;
        checks++;
        if ({busy, dwait} !== 3'b011) begin errors++; $display("FAIL wd_idle got %b want 011", {busy, dwait}); end
        @(negedge CLK);
        ramstate = ACCESS;
        #1;
        checks++;
        if ({busy, gnt_cpu, dwait} !== 4'b1101) begin errors++; $display("FAIL wd_regrant got %b want 1101", {busy, gnt_cpu, dwait}); end
        @(negedge CLK);
        dREN = 2'b00; ramstate = FREE;
    endtask

    task automatic test_stuck_busy();
        @(negedge CLK);
        dREN = 2'b11; daddr[0] = 32'h600; daddr[1] = 32'h700; ramstate = BUSY;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK); #1;
            checks++;
            if ({busy, timeout, gnt_cpu, dwait} !== 5'b10011) begin
                errors++; $display("FAIL to_hold%0d got %b want 10011", c, {busy, timeout, gnt_cpu, dwait});
            end
        end
        @(negedge CLK); #1;
        checks++;
        if ({busy, timeout, dwait} !== 4'b0111) begin errors++; $display("FAIL to_pulse got %b want 0111", {busy, timeout, dwait}); end
        @(negedge CLK);
        ramstate = ACCESS;
        #1;
        checks++;
        if ({busy, timeout, gnt_cpu, dwait} !== 5'b10101) begin
            errors++; $display("FAIL to_next got %b want 10101", {busy, timeout, gnt_cpu, dwait});
        end
`else
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK); #1;
            checks++;
            if ({busy, timeout, gnt_cpu, dwait} !== 5'b10011) begin
                errors++; $display("FAIL hold%0d got %b want 10011", c, {busy, timeout, gnt_cpu, dwait});
            end
        end
        ramstate = ACCESS;
        #1;
        checks++;
        if (dwait !== 2'b10) begin errors++; $display("FAIL hold_done dwait=%b want 10", dwait); end
`endif
        @(negedge CLK);
        dREN = 2'b00; ramstate = FREE;
    endtask

    initial begin
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
        test_reset();
        test_single_fetch();
        test_priority();
        test_round_robin();
        test_withdrawal();
        test_stuck_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
